// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter with open-drain drive-low enables.
// Optional build macro PS2_TX_ACK_CHECK_EN: a device NACK at the ACK bit raises tx_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int BIT_TIMEOUT    = 200000
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t      state_reg, state_next;
  logic        clk_meta_reg, clk_sync_reg, clk_prev_reg;
  logic        data_meta_reg, data_sync_reg;
  logic [7:0]  byte_reg, byte_next;
  logic        parity_reg, parity_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [20:0] wdog_reg, wdog_next;
  logic        data_low_reg, data_low_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        fe;
`ifdef PS2_TX_ACK_CHECK_EN
  logic        ack_reg, ack_next;
`endif

  assign fe = clk_prev_reg & ~clk_sync_reg;

  // Synchronizers idle high so a released bus never looks like an edge after reset.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      clk_prev_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2_clk_i;
      clk_sync_reg  <= clk_meta_reg;
      clk_prev_reg  <= clk_sync_reg;
      data_meta_reg <= ps2_data_i;
      data_sync_reg <= data_meta_reg;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      byte_reg     <= '0;
      parity_reg   <= 1'b0;
      bit_cnt_reg  <= '0;
      wdog_reg     <= '0;
      data_low_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      parity_reg   <= parity_next;
      bit_cnt_reg  <= bit_cnt_next;
      wdog_reg     <= wdog_next;
      data_low_reg <= data_low_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

`ifdef PS2_TX_ACK_CHECK_EN
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) ack_reg <= 1'b0;
    else        ack_reg <= ack_next;
  end
`endif

  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    parity_next   = parity_reg;
    bit_cnt_next  = bit_cnt_reg;
    wdog_next     = wdog_reg + 21'd1;
    data_low_next = data_low_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_next      = ack_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        data_low_next = 1'b0;
        if (tx_valid) begin
          byte_next    = tx_data;
          parity_next  = ~^tx_data;
          bit_cnt_next = '0;
          state_next   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (wdog_reg == 21'(INHIBIT_CYCLES - 1)) begin
          data_low_next = 1'b1;
          state_next    = S_RTS;
        end
      end
      S_RTS: begin
        if (fe) begin
          data_low_next = ~byte_reg[0];
          bit_cnt_next  = 4'd1;
          state_next    = S_SHIFT;
        end else if (wdog_reg == 21'(START_TIMEOUT - 1)) begin
          data_low_next = 1'b0;
          done_next     = 1'b1;
          err_next      = 1'b1;
          state_next    = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (fe) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd9) begin
            data_low_next = 1'b0;
            state_next    = S_ACK;
          end else if (bit_cnt_reg == 4'd8) begin
            data_low_next = ~parity_reg;
          end else begin
            data_low_next = ~byte_reg[bit_cnt_reg[2:0]];
          end
        end else if (wdog_reg == 21'(BIT_TIMEOUT - 1)) begin
          data_low_next = 1'b0;
          done_next     = 1'b1;
          err_next      = 1'b1;
          state_next    = S_IDLE;
        end
      end
      S_ACK: begin
        if (fe) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
`ifdef PS2_TX_ACK_CHECK_EN
          ack_next     = data_sync_reg;
`endif
          state_next   = S_WAIT_IDLE;
        end else if (wdog_reg == 21'(BIT_TIMEOUT - 1)) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_reg && data_sync_reg) begin
          done_next  = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
          err_next   = ack_reg;
`else
          err_next   = 1'b0;
`endif
          state_next = S_IDLE;
        end else if (wdog_reg == 21'(BIT_TIMEOUT - 1)) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        data_low_next = 1'b0;
        state_next    = S_IDLE;
      end
    endcase
    // Our own clock pull-down produces a falling edge during INHIBIT; it must not stretch the hold time.
    if (state_next != state_reg || state_reg == S_IDLE || (fe && state_reg != S_INHIBIT))
      wdog_next = '0;
  end

  assign tx_ready           = (state_reg == S_IDLE);
  assign busy               = (state_reg != S_IDLE);
  assign ps2_clk_drive_low  = (state_reg == S_INHIBIT);
  assign ps2_data_drive_low = data_low_reg;
  assign tx_done            = done_reg;
  assign tx_err             = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks frames over a wired-AND bus.
// Timing parameters are scaled down so every scenario fits a short simulation.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int ST   = 3000;
  localparam int BT   = 500;
  localparam int HALF = 20;

  logic       clk_100mhz;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk;
  logic       dev_data;

  int n_vec;
  int n_err;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (ST),
    .BIT_TIMEOUT   (BT)
  ) dut (
    .clk_100mhz        (clk_100mhz),
    .rst_n             (rst_n),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .ps2_clk_i         (ps2_clk_i),
    .ps2_data_i        (ps2_data_i),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .busy              (busy),
    .tx_done           (tx_done),
    .tx_err            (tx_err)
  );

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_i  = ~ps2_clk_drive_low & dev_clk;
  assign ps2_data_i = ~ps2_data_drive_low & dev_data;

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 1000 && tx_ready !== 1'b1; i++) tick();
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    n_vec++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_%02h: tx_ready=%0b busy=%0b, required tx_ready=0 busy=1", b, tx_ready, busy);
    end
  endtask

  // Keyboard model: measure the inhibit, then clock n_edges falling edges, sampling data mid-high.
  task automatic device_frame(input int n_edges, input logic ack_bit,
                              output logic [10:0] seen, output int inh);
    seen = '0;
    inh  = 0;
    for (int i = 0; i < INH * 4 && ps2_clk_drive_low !== 1'b1; i++) tick();
    for (int i = 0; i < INH * 4 && ps2_clk_drive_low === 1'b1; i++) begin
      inh++;
      tick();
    end
    n_vec++;
    if (ps2_data_drive_low !== 1'b1) begin
      n_err++;
      $display("FAIL rts_start_bit: data_drive_low=%0b at clock release, required 1", ps2_data_drive_low);
    end
    repeat (5) tick();
    for (int e = 0; e < n_edges; e++) begin
      repeat (HALF / 2) tick();
      seen[e] = ps2_data_i;
      if (e == 10) dev_data = ack_bit;
      repeat (HALF / 2) tick();
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int limit, output bit got, output logic err, output int cyc);
    got = 1'b0;
    err = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      cyc++;
      if (tx_done === 1'b1) begin
        got = 1'b1;
        err = tx_err;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({tx_ready, busy, tx_done, tx_err, ps2_clk_drive_low, ps2_data_drive_low} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_outputs: rdy,busy,done,err,cdl,ddl=%b required 100000",
               {tx_ready, busy, tx_done, tx_err, ps2_clk_drive_low, ps2_data_drive_low});
    end
    rst_n = 1'b1;
    tick();
    $display("reset released: tx_ready=%0b busy=%0b", tx_ready, busy);
  endtask

  task automatic test_send_ed();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    send_byte(8'hED);
    device_frame(11, 1'b0, seen, inh);
    n_vec++;
    if (inh != INH) begin
      n_err++;
      $display("FAIL inhibit_len: %0d cycles, required %0d", inh, INH);
    end
    n_vec++;
    if (seen !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
      n_err++;
      $display("FAIL frame_ED: sampled %b, required %b", seen, {1'b1, 1'b1, 8'hED, 1'b0});
    end
    wait_done(200, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_ED: got=%0b err=%0b rdy=%0b, required 1 0 1", got, err, tx_ready);
    end
    tick();
    n_vec++;
    if (tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_width: tx_done=%0b one cycle later, required 0", tx_done);
    end
    $display("tx 0xED: inhibit=%0d bits=%b done=%0b err=%0b", inh, seen, got, err);
  endtask

  task automatic test_back_to_back();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    send_byte(8'h02);
    device_frame(11, 1'b0, seen, inh);
    n_vec++;
    if (seen !== {1'b1, 1'b0, 8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL frame_02: sampled %b, required %b", seen, {1'b1, 1'b0, 8'h02, 1'b0});
    end
    wait_done(200, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_02: got=%0b err=%0b rdy=%0b, required 1 0 1", got, err, tx_ready);
    end
    $display("tx 0x02: bits=%b done=%0b err=%0b", seen, got, err);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_valid = 1'b0;
    n_vec++;
    if (tx_ready !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: rdy=%0b done=%0b, required 0 0", tx_ready, tx_done);
    end
    device_frame(11, 1'b0, seen, inh);
    n_vec++;
    if (seen !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL frame_00: sampled %b, required %b", seen, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    wait_done(200, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL done_00: got=%0b err=%0b, required 1 0", got, err);
    end
    $display("tx 0x00: bits=%b done=%0b err=%0b", seen, got, err);
  endtask

  task automatic test_start_timeout();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    send_byte(8'h11);
    device_frame(0, 1'b0, seen, inh);
    wait_done(ST * 2, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== 1'b1) begin
      n_err++;
      $display("FAIL start_timeout_done: got=%0b err=%0b, required 1 1", got, err);
    end
    n_vec++;
    if (cyc < ST - 6 || cyc > ST - 4) begin
      n_err++;
      $display("FAIL start_timeout_time: %0d cycles after release+5, required %0d", cyc, ST - 5);
    end
    n_vec++;
    if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_timeout_lines: cdl=%0b ddl=%0b busy=%0b, required 0 0 0",
               ps2_clk_drive_low, ps2_data_drive_low, busy);
    end
    $display("tx 0x11 no device clock: done=%0b err=%0b after %0d cycles", got, err, cyc + 5);
  endtask

  task automatic test_bit_timeout();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    send_byte(8'h3C);
    device_frame(5, 1'b0, seen, inh);
    wait_done(BT * 2, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== 1'b1) begin
      n_err++;
      $display("FAIL bit_timeout_done: got=%0b err=%0b, required 1 1", got, err);
    end
    n_vec++;
    if (cyc < BT + 3 - HALF - 1 || cyc > BT + 3 - HALF + 1) begin
      n_err++;
      $display("FAIL bit_timeout_time: %0d cycles, required %0d", cyc, BT + 3 - HALF);
    end
    n_vec++;
    if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      n_err++;
      $display("FAIL bit_timeout_lines: cdl=%0b ddl=%0b, required 0 0", ps2_clk_drive_low, ps2_data_drive_low);
    end
    $display("tx 0x3C device stops after 5 edges: done=%0b err=%0b", got, err);
  endtask

  task automatic test_ack_nack();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    logic exp_err;
`ifdef PS2_TX_ACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_byte(8'hFF);
    device_frame(11, 1'b1, seen, inh);
    n_vec++;
    if (seen !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL frame_FF: sampled %b, required %b", seen, {1'b1, 1'b1, 8'hFF, 1'b0});
    end
    wait_done(200, got, err, cyc);
    n_vec++;
    if (got !== 1'b1 || err !== exp_err) begin
      n_err++;
      $display("FAIL nack_FF: got=%0b err=%0b, required 1 %0b", got, err, exp_err);
    end
    $display("tx 0xFF device NACK: bits=%b done=%0b err=%0b", seen, got, err);
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] seen;
    int inh, cyc;
    bit got;
    logic err;
    send_byte(8'h55);
    device_frame(4, 1'b0, seen, inh);
    n_vec++;
    if (busy !== 1'b1 || ps2_data_drive_low !== 1'b1) begin
      n_err++;
      $display("FAIL shift_D3: busy=%0b ddl=%0b, required 1 1", busy, ps2_data_drive_low);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, tx_ready, busy} !== 4'b0010) begin
      n_err++;
      $display("FAIL async_reset: cdl,ddl,rdy,busy=%b, required 0010",
               {ps2_clk_drive_low, ps2_data_drive_low, tx_ready, busy});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    wait_done(BT * 2, got, err, cyc);
    n_vec++;
    if (got !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_no_done: got=%0b rdy=%0b, required 0 1", got, tx_ready);
    end
    $display("tx 0x55 reset at edge 4: done seen=%0b", got);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_start_timeout();
    test_bit_timeout();
    test_ack_nack();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
